universal_shift_register: RTL and testbench

4-bit (parameterisable) universal shift register with a 2-bit mode control selecting hold, shift right, shift left or parallel load each clock. It is a small leaf datapath block: a parallel word enters on `in`, and the register contents are always visible on `q`. It is used wherever a loadable, bidirectional shifting register is needed.

---
 rtl/universal_shift_register.sv | 44 ++++
 tb/tb_universal_shift_register.sv | 136 +++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// Universal shift register: hold, shift right, shift left or parallel load
// on each rising clock edge, selected by a 2-bit mode input.
//
// Ports:
//   clk  - system clock, rising-edge active
//   rst  - asynchronous active-low reset, clears the register
//   in   - WIDTH-bit parallel load data (used only in mode 11)
//   cnt  - mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   q    - WIDTH-bit register contents, driven directly from flops
module universal_shift_register #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       cnt,
    output logic [WIDTH-1:0] q
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_SHL   = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    logic [WIDTH-1:0] r_q;

    // Register update; an unknown mode falls to the default arm and holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else begin
            case (cnt)
                MODE_HOLD: r_q <= r_q;
                MODE_SHR:  r_q <= {1'b0, r_q[WIDTH-1:1]};
                MODE_SHL:  r_q <= {r_q[WIDTH-2:0], 1'b0};
                MODE_LOAD: r_q <= in;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register: directed steps from the
// test plan followed by randomized modes/data with occasional async resets,
// all checked against an arithmetic reference model.
module tb_universal_shift_register;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] in;
    logic [1:0]   cnt;
    logic [W-1:0] q;

    int n_pass;
    int n_total;
    int mdl;

    universal_shift_register #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .in  (in),
        .cnt (cnt),
        .q   (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the register as an integer in [0, 2**W).
    function automatic int model_next(int cur, int mode, int data);
        case (mode)
            1:       return cur / 2;
            2:       return (cur * 2) % (1 << W);
            3:       return data % (1 << W);
            default: return cur;
        endcase
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input int exp_i);
        logic [W-1:0] exp_v;
        exp_v = W'(exp_i);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: q=%b expected=%b", tag, obs, exp_v);
    endtask

    // Apply inputs, take one rising edge, then compare shortly after it.
    task automatic step(input logic [1:0] c, input logic [W-1:0] d, input string tag);
        cnt = c;
        in  = d;
        @(posedge clk);
        #1;
        if (rst) mdl = model_next(mdl, int'(c), int'(d));
        check(tag, q, mdl);
    endtask

    // Assert reset between edges, confirm immediate clear and that the
    // following edge is ignored, then release away from any edge.
    task automatic mid_reset(input string tag);
        #2;
        rst = 1'b0;
        mdl = 0;
        #1;
        check({tag, "_async"}, q, mdl);
        @(posedge clk);
        #1;
        check({tag, "_held"}, q, mdl);
        rst = 1'b1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        mdl     = 0;
        rst     = 1'b0;
        cnt     = 2'b00;
        in      = '0;
        #1;
        check("reset_state", q, 0);
        @(posedge clk);
        #1;
        check("reset_edge_ignored", q, 0);
        rst = 1'b1;

        // 1. async reset from 1010
        step(2'b11, 4'b1010, "load_1010");
        mid_reset("t1");

        // 2. load then hold
        step(2'b11, 4'b1100, "t2_load");
        step(2'b00, 4'b0011, "t2_hold1");
        step(2'b00, 4'b0011, "t2_hold2");

        // 3. shift right drains to zero
        step(2'b01, 4'b1111, "t3_shr1");
        step(2'b01, 4'b1111, "t3_shr2");
        step(2'b01, 4'b1111, "t3_shr3");
        step(2'b01, 4'b1111, "t3_shr4");
        step(2'b01, 4'b1111, "t3_shr5");
        check("t3_zero", q, 0);

        // 4. shift left drains to zero
        step(2'b11, 4'b1100, "t4_load");
        step(2'b10, 4'b0000, "t4_shl1");
        step(2'b10, 4'b0000, "t4_shl2");
        step(2'b10, 4'b0000, "t4_shl3");
        check("t4_zero", q, 0);

        // 5. load overrides contents, per-cycle mode changes
        step(2'b11, 4'b0110, "t5_pre");
        step(2'b11, 4'b1001, "t5_load");
        step(2'b11, 4'b1011, "t5_m11");
        step(2'b01, 4'b1011, "t5_m01");
        step(2'b10, 4'b1011, "t5_m10");
        step(2'b00, 4'b1011, "t5_m00");
        check("t5_final", q, 10);

        // 6. reset mid-shift, then load on release
        step(2'b11, 4'b1111, "t6_load");
        step(2'b01, 4'b1111, "t6_shr");
        check("t6_0111", q, 7);
        mid_reset("t6");
        step(2'b11, 4'b0101, "t6_reload");
        check("t6_0101", q, 5);

        // Randomized modes and data with occasional mid-cycle resets
        for (int i = 0; i < 300; i++) begin
            step(2'($urandom_range(0, 3)), W'($urandom), "rand");
            if ($urandom_range(0, 19) == 0) mid_reset("rand_rst");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
